// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Combinational lookup, single-edge update, saturating mispredict count.
//
// Ports:
//   clk, rst (async, active-low)
//   lookup_pc -> pred_hit, pred_taken, pred_target
//   update_valid/pc/taken/target/mispredict : resolved branch feedback
//   invalidate : clear every valid bit
//   mispredict_count : saturating 32-bit mispredict counter
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_mispredict,
    input  logic            invalidate,
    output logic [31:0]     mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - CNT_ONE;

    logic             r_valid [ENTRIES];
    logic [TAG_W-1:0] r_tag   [ENTRIES];
    logic [XLEN-1:0]  r_tgt   [ENTRIES];
    logic [CNT_W-1:0] r_cnt   [ENTRIES];
    logic [31:0]      r_mcnt;

    logic [IDX_W-1:0] w_lidx;
    logic [TAG_W-1:0] w_ltag;
    logic             w_lhit;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_utag;
    logic             w_uhit;

    assign w_lidx = lookup_pc[IDX_W+1:2];
    assign w_ltag = lookup_pc[XLEN-1:IDX_W+2];
    assign w_lhit = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);

    assign w_uidx = update_pc[IDX_W+1:2];
    assign w_utag = update_pc[XLEN-1:IDX_W+2];
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    // Lookup reads registered state only, so a same-cycle update is not seen.
    assign pred_hit    = w_lhit;
    assign pred_taken  = w_lhit && r_cnt[w_lidx][CNT_W-1];
    assign pred_target = w_lhit ? r_tgt[w_lidx] : '0;

    assign mispredict_count = r_mcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_tgt[i]   <= '0;
                r_cnt[i]   <= CNT_WNT;
            end
        end else if (invalidate) begin
            // Simultaneous update is intentionally dropped.
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
            end
        end else if (update_valid) begin
            if (w_uhit) begin
                if (update_taken) begin
                    r_tgt[w_uidx] <= update_target;
                    if (r_cnt[w_uidx] != CNT_MAX) begin
                        r_cnt[w_uidx] <= r_cnt[w_uidx] + CNT_ONE;
                    end
                end else if (r_cnt[w_uidx] != '0) begin
                    r_cnt[w_uidx] <= r_cnt[w_uidx] - CNT_ONE;
                end
            end else if (update_taken) begin
                // Allocate on taken miss, replacing any aliasing entry.
                r_valid[w_uidx] <= 1'b1;
                r_tag[w_uidx]   <= w_utag;
                r_tgt[w_uidx]   <= update_target;
                r_cnt[w_uidx]   <= CNT_WT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mcnt <= '0;
        end else if (update_valid && update_mispredict) begin
            if (r_mcnt != 32'hFFFF_FFFF) begin
                r_mcnt <= r_mcnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (32/16/2).
// Linear step sequence with hand-computed expectations.
module tb_branch_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispredict;
    logic        invalidate;
    logic [31:0] mispredict_count;

    int checks = 0;
    int errors = 0;

    branch_predictor #(
        .XLEN(32),
        .ENTRIES(16),
        .CNT_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .lookup_pc(lookup_pc),
        .pred_hit(pred_hit),
        .pred_taken(pred_taken),
        .pred_target(pred_target),
        .update_valid(update_valid),
        .update_pc(update_pc),
        .update_taken(update_taken),
        .update_target(update_target),
        .update_mispredict(update_mispredict),
        .invalidate(invalidate),
        .mispredict_count(mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic hit, input logic tk,
                        input logic [31:0] tgt);
        lookup_pc = pc;
        #1;
        chk({tag, ".hit"}, {31'd0, pred_hit}, {31'd0, hit});
        chk({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, tk});
        chk({tag, ".target"}, pred_target, tgt);
    endtask

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic mis);
        update_valid      = 1'b1;
        update_pc         = pc;
        update_taken      = tk;
        update_target     = tgt;
        update_mispredict = mis;
        edge1();
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
    endtask

    initial begin
        rst               = 1'b0;
        lookup_pc         = 32'h100;
        update_valid      = 1'b1;
        update_pc         = 32'h100;
        update_taken      = 1'b1;
        update_target     = 32'h200;
        update_mispredict = 1'b1;
        invalidate        = 1'b0;

        // Update held across an edge while in reset must be ignored.
        #2;
        look("in_reset", 32'h100, 1'b0, 1'b0, 32'h0);
        edge1();
        chk("in_reset.mcnt", mispredict_count, 32'd0);
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
        rst               = 1'b1;
        look("post_reset", 32'h100, 1'b0, 1'b0, 32'h0);
        chk("post_reset.mcnt", mispredict_count, 32'd0);

        // Allocate 0x100; same-cycle lookup sees old contents.
        update_valid      = 1'b1;
        update_pc         = 32'h100;
        update_taken      = 1'b1;
        update_target     = 32'h200;
        update_mispredict = 1'b1;
        look("no_bypass", 32'h100, 1'b0, 1'b0, 32'h0);
        edge1();
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
        look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
        chk("alloc.mcnt", mispredict_count, 32'd1);

        // Counter 2 -> 1 -> 0 -> 0, target kept.
        upd(32'h100, 1'b0, 32'hDEAD, 1'b0);
        look("nt1", 32'h100, 1'b1, 1'b0, 32'h200);
        upd(32'h100, 1'b0, 32'hDEAD, 1'b0);
        upd(32'h100, 1'b0, 32'hDEAD, 1'b0);
        look("nt3", 32'h100, 1'b1, 1'b0, 32'h200);

        // From 0: taken -> 1 (low saturation check), target rewritten.
        upd(32'h100, 1'b1, 32'h204, 1'b0);
        look("t1", 32'h100, 1'b1, 1'b0, 32'h204);
        upd(32'h100, 1'b1, 32'h208, 1'b0);
        look("t2", 32'h100, 1'b1, 1'b1, 32'h208);

        // 2 -> 3 -> 3, then not-taken -> 2 (high saturation check).
        upd(32'h100, 1'b1, 32'h208, 1'b0);
        upd(32'h100, 1'b1, 32'h208, 1'b0);
        upd(32'h100, 1'b0, 32'h0, 1'b0);
        look("sat_hi", 32'h100, 1'b1, 1'b1, 32'h208);

        // Second index entry.
        upd(32'h104, 1'b1, 32'h500, 1'b0);
        look("idx1", 32'h104, 1'b1, 1'b1, 32'h500);

        // Mispredict without update_valid is ignored.
        update_mispredict = 1'b1;
        edge1();
        update_mispredict = 1'b0;
        chk("mis_novalid", mispredict_count, 32'd1);

        // Not-taken miss allocates nothing.
        upd(32'h180, 1'b0, 32'h700, 1'b0);
        look("nt_miss", 32'h180, 1'b0, 1'b0, 32'h0);
        look("nt_miss.keep", 32'h100, 1'b1, 1'b1, 32'h208);

        // Alias into index 0 replaces 0x100.
        upd(32'h140, 1'b1, 32'h300, 1'b0);
        look("alias.new", 32'h140, 1'b1, 1'b1, 32'h300);
        look("alias.old", 32'h100, 1'b0, 1'b0, 32'h0);
        look("alias.other", 32'h104, 1'b1, 1'b1, 32'h500);

        // Invalidate beats a simultaneous taken update.
        invalidate = 1'b1;
        upd(32'h40, 1'b1, 32'h400, 1'b0);
        invalidate = 1'b0;
        look("inv.40", 32'h40, 1'b0, 1'b0, 32'h0);
        look("inv.140", 32'h140, 1'b0, 1'b0, 32'h0);
        look("inv.104", 32'h104, 1'b0, 1'b0, 32'h0);
        chk("inv.mcnt", mispredict_count, 32'd1);

        upd(32'h40, 1'b1, 32'h440, 1'b0);
        look("realloc", 32'h40, 1'b1, 1'b1, 32'h440);

        // Preload the counter near its ceiling.
        force dut.r_mcnt = 32'hFFFF_FFFD;
        #1;
        release dut.r_mcnt;
        #1;
        upd(32'h40, 1'b0, 32'h0, 1'b1);
        chk("mcnt.fe", mispredict_count, 32'hFFFF_FFFE);
        upd(32'h40, 1'b0, 32'h0, 1'b1);
        chk("mcnt.ff", mispredict_count, 32'hFFFF_FFFF);
        upd(32'h40, 1'b0, 32'h0, 1'b1);
        chk("mcnt.hold", mispredict_count, 32'hFFFF_FFFF);

        // Async reset pulse between edges.
        rst = 1'b0;
        #1;
        chk("arst.mcnt", mispredict_count, 32'd0);
        look("arst.40", 32'h40, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        upd(32'h44, 1'b1, 32'h600, 1'b1);
        look("arst.first", 32'h44, 1'b1, 1'b1, 32'h600);
        chk("arst.first.mcnt", mispredict_count, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
